multdiv: RTL

Iterative signed 32-bit multiply/divide unit that sits beside the `processor` datapath in `skeleton`, clocked from `processor_clock`. The processor forwards the two ALU operands and a one-cycle `ctrl_MULT`/`ctrl_DIV` pulse when it decodes `mul`/`div`. It stalls until `data_resultRDY` pulses, then writes `data_result` to the regfile, or `$rstatus` when `data_exception` is set. Multiply uses radix-2 Booth recoding; divide uses restoring division on magnitudes with sign fix-up.

---
 rtl/multdiv_pkg.sv | 16 +
 rtl/multdiv_ctrl.sv | 79 +++++++
 rtl/multdiv.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM state
// encodings, default operand width and the most negative 32-bit value.
package multdiv_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [WIDTH_DEF-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage : multdiv_pkg

// File: rtl/multdiv_ctrl.sv
// Sequencer for multdiv: tracks the active operation and counts iterations.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a start pulse
//   MUL     | one Booth step per cycle, WIDTH cycles
//   DIV     | one restoring-division step per cycle, WIDTH cycles
//   DONE    | result is final; datapath captures it and strobes ready
//
// A start pulse in any state reloads and restarts; multiply beats divide.
// A divide by zero skips the iterations and goes straight to DONE.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic i_start_mul,
  input  logic i_start_div,
  input  logic i_div_zero,
  output logic o_step_en,
  output logic o_op_is_div,
  output logic o_load,
  output logic o_finish
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             w_start;

  assign w_start = i_start_mul | i_start_div;

  // State and iteration counter; a start pulse always wins over progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
    end else if (w_start) begin
      r_cnt    <= '0;
      r_is_div <= ~i_start_mul;
      if (i_start_mul)
        r_state <= ST_MUL;
      else if (i_div_zero)
        r_state <= ST_DONE;
      else
        r_state <= ST_DIV;
    end else begin
      case (r_state)
        ST_MUL, ST_DIV: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_STEP)
            r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobes only feed datapath registers, so gating them with the start
  // pulse does not create an input-to-output path.
  assign o_load      = w_start;
  assign o_step_en   = ((r_state == ST_MUL) || (r_state == ST_DIV)) && !w_start;
  assign o_finish    = (r_state == ST_DONE) && !w_start;
  assign o_op_is_div = r_is_div;

endmodule : multdiv_ctrl

// File: rtl/multdiv.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring on
// magnitudes with sign fix-up). One step per clock, result strobed once.
module multdiv
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  logic w_step_en;
  logic w_op_is_div;
  logic w_load;
  logic w_finish;
  logic w_div_zero;
  logic w_load_div;

  // Shared working registers. r_acc is the Booth accumulator or the
  // division remainder; it carries one guard bit so that subtracting a
  // multiplicand of INT_MIN does not wrap. r_q is the Booth multiplier or
  // the dividend/quotient shift register; r_m is multiplicand or |divisor|.
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_q;
  logic             r_qm1;
  logic [WIDTH-1:0] r_m;
  logic             r_neg;
  logic             r_div_zero;

  logic [WIDTH-1:0] r_result;
  logic             r_exception;
  logic             r_rdy;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;

  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH:0]   w_booth_sum;

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_prod_top;
  logic               w_mul_ovf;
  logic [WIDTH-1:0]   w_quot;
  logic               w_div_ovf;

  assign w_div_zero = (data_operandB == '0);
  assign w_load_div = ctrl_DIV & ~ctrl_MULT;

  multdiv_ctrl #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .clock       (clock),
    .reset       (reset),
    .i_start_mul (ctrl_MULT),
    .i_start_div (ctrl_DIV),
    .i_div_zero  (w_div_zero),
    .o_step_en   (w_step_en),
    .o_op_is_div (w_op_is_div),
    .o_load      (w_load),
    .o_finish    (w_finish)
  );

  assign w_abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // Booth recoding of {q0, q-1}: 01 adds, 10 subtracts the multiplicand.
  assign w_m_ext = {r_m[WIDTH-1], r_m};
  always_comb begin
    w_booth_sum = r_acc;
    case ({r_q[0], r_qm1})
      2'b01:   w_booth_sum = r_acc + w_m_ext;
      2'b10:   w_booth_sum = r_acc - w_m_ext;
      default: w_booth_sum = r_acc;
    endcase
  end

  // Restoring division: shift next dividend bit into the remainder and try
  // subtracting the divisor; a non-negative trial yields a quotient 1.
  assign w_rem_sh = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_m};

  // Load operands on a start pulse, otherwise advance one step.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc      <= '0;
      r_q        <= '0;
      r_qm1      <= 1'b0;
      r_m        <= '0;
      r_neg      <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (w_load) begin
      r_acc      <= '0;
      r_qm1      <= 1'b0;
      r_q        <= w_load_div ? w_abs_a : data_operandB;
      r_m        <= w_load_div ? w_abs_b : data_operandA;
      r_neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      r_div_zero <= w_load_div & w_div_zero;
    end else if (w_step_en) begin
      if (w_op_is_div) begin
        if (!w_trial[WIDTH]) begin
          r_acc <= w_trial;
          r_q   <= {r_q[WIDTH-2:0], 1'b1};
        end else begin
          r_acc <= w_rem_sh;
          r_q   <= {r_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        r_acc <= {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
        r_q   <= {w_booth_sum[0], r_q[WIDTH-1:1]};
        r_qm1 <= r_q[0];
      end
    end
  end

  // The guard bit equals bit WIDTH-1 once all steps are done, so the
  // 2*WIDTH product is the low accumulator bits over the multiplier.
  assign w_prod     = {r_acc[WIDTH-1:0], r_q};
  assign w_prod_top = w_prod[2*WIDTH-1:WIDTH-1];
  assign w_mul_ovf  = !((&w_prod_top) || !(|w_prod_top));

  // A positive quotient with the top bit set can only be INT_MIN / -1.
  assign w_quot    = r_neg ? -r_q : r_q;
  assign w_div_ovf = ~r_neg & r_q[WIDTH-1];

  // Registered outputs: capture the result once per completed operation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_result    <= '0;
      r_exception <= 1'b0;
      r_rdy       <= 1'b0;
    end else begin
      r_rdy <= w_finish;
      if (w_finish) begin
        if (!w_op_is_div) begin
          r_result    <= w_prod[WIDTH-1:0];
          r_exception <= w_mul_ovf;
        end else if (r_div_zero) begin
          r_result    <= '0;
          r_exception <= 1'b1;
        end else begin
          r_result    <= w_quot;
          r_exception <= w_div_ovf;
        end
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exception;
  assign data_resultRDY = r_rdy;

endmodule : multdiv
